// File: rtl/uart_tx.sv
// uart_tx: byte-serial UART transmitter, 8 data bits, no parity, 1 or 2 stop
// bits, LSB first, idle-high line. A one-entry holding register lets the
// producer queue the next byte mid-frame so frames chain with no idle gap.
module uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic           STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [2:0]      bit_idx_r, bit_idx_s;
  logic            stop_cnt_r, stop_cnt_s;
  logic [7:0]      shift_r, shift_s;
  logic [7:0]      hold_r, hold_s;
  logic            hold_full_r, hold_full_s;
  logic            tx_r, tx_s;
  logic            ready_r, ready_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;

  logic            accept_s;
  logic            bit_end_s;
  logic            final_s;

  // Next-state, counter, shift/hold and registered-output computation.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    bit_idx_s   = bit_idx_r;
    stop_cnt_s  = stop_cnt_r;
    shift_s     = shift_r;
    hold_s      = hold_r;
    hold_full_s = hold_full_r;
    tx_s        = 1'b1;
    accept_s    = data_valid && !hold_full_r;
    bit_end_s   = (cnt_r == CNT_ZERO);
    final_s     = (state_r == STOP) && bit_end_s && (stop_cnt_r == STOP_LAST);

    case (state_r)
      IDLE: begin
        cnt_s = CNT_ZERO;
        if (accept_s) begin
          shift_s   = data_in;
          cnt_s     = CNT_LAST;
          bit_idx_s = 3'd0;
          state_s   = START;
        end else begin
          state_s = IDLE;
        end
      end

      START: begin
        if (bit_end_s) begin
          cnt_s     = CNT_LAST;
          bit_idx_s = 3'd0;
          state_s   = DATA;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end

      DATA: begin
        if (bit_end_s) begin
          cnt_s   = CNT_LAST;
          shift_s = {1'b0, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            stop_cnt_s = 1'b0;
            state_s    = STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end

      STOP: begin
        if (bit_end_s) begin
          if (stop_cnt_r == STOP_LAST) begin
            // Final stop edge: chain the held byte, or a byte offered right now.
            if (hold_full_r) begin
              shift_s     = hold_r;
              hold_full_s = 1'b0;
              cnt_s       = CNT_LAST;
              bit_idx_s   = 3'd0;
              state_s     = START;
            end else if (accept_s) begin
              shift_s   = data_in;
              cnt_s     = CNT_LAST;
              bit_idx_s = 3'd0;
              state_s   = START;
            end else begin
              cnt_s   = CNT_ZERO;
              state_s = IDLE;
            end
          end else begin
            stop_cnt_s = stop_cnt_r + 1'b1;
            cnt_s      = CNT_LAST;
          end
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end

      default: begin
        cnt_s   = CNT_ZERO;
        state_s = IDLE;
      end
    endcase

    // Mid-frame accepts park in the holding register.
    if (accept_s && (state_r != IDLE) && !final_s) begin
      hold_s      = data_in;
      hold_full_s = 1'b1;
    end else begin
      hold_s = hold_s;
    end

    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
      default: tx_s = 1'b1;
    endcase

    ready_s = !hold_full_s;
    busy_s  = (state_s != IDLE);
    done_s  = (state_s == STOP) && (cnt_s == CNT_ZERO) && (stop_cnt_s == STOP_LAST);
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      bit_idx_r   <= 3'd0;
      stop_cnt_r  <= 1'b0;
      shift_r     <= 8'h00;
      hold_r      <= 8'h00;
      hold_full_r <= 1'b0;
      tx_r        <= 1'b1;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      bit_idx_r   <= bit_idx_s;
      stop_cnt_r  <= stop_cnt_s;
      shift_r     <= shift_s;
      hold_r      <= hold_s;
      hold_full_r <= hold_full_s;
      tx_r        <= tx_s;
      ready_r     <= ready_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign tx      = tx_r;
  assign ready   = ready_r;
  assign busy    = busy_r;
  assign tx_done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx. Accepted bytes are queued as
// expectations; a line monitor decodes each frame cycle by cycle against the
// ideal 8N1 waveform and compares against the queue.
module tb_uart_tx;

  localparam int CPB    = 104;
  localparam int FRAME  = 10 * CPB;
  localparam int FRAME2 = 11 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       ready, tx, busy, tx_done;

  logic [7:0] b_data_in = 8'h00;
  logic       b_valid = 1'b0;
  logic       b_ready, b_tx, b_busy, b_tx_done;

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .ready(ready), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .data_in(b_data_in), .data_valid(b_valid),
    .ready(b_ready), .tx(b_tx), .busy(b_busy), .tx_done(b_tx_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         frames_seen = 0;
  int         accept_cyc = 0;

  function automatic void check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Ideal line level at cycle c of a frame carrying byte b.
  function automatic logic line_level(input logic [7:0] b, input int c);
    int idx;
    idx = c / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  // Line monitor / scoreboard consumer.
  bit         m_in_frame = 1'b0;
  bit         m_post = 1'b0;
  int         m_c = 0;
  int         m_wave_err = 0;
  int         m_done_err = 0;
  int         m_busy_err = 0;
  logic [7:0] m_cur = 8'h00;
  logic [7:0] m_dec = 8'h00;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_in_frame = 1'b0;
        m_post     = 1'b0;
      end else begin
        if (!m_in_frame && tx == 1'b0) begin
          m_in_frame = 1'b1;
          m_c = 0; m_wave_err = 0; m_done_err = 0; m_busy_err = 0; m_dec = 8'h00;
          start_q.push_back(cyc);
          check("frame_expected", (exp_q.size() > 0) ? 1 : 0, 1);
          m_cur = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        end else if (!m_in_frame && m_post) begin
          check("busy_fall", busy, 0);
        end
        m_post = 1'b0;
        if (m_in_frame) begin
          if (tx !== line_level(m_cur, m_c)) m_wave_err++;
          if (tx_done !== (m_c == FRAME - 1)) m_done_err++;
          if (busy !== 1'b1) m_busy_err++;
          if ((m_c % CPB) == CPB / 2 && m_c / CPB >= 1 && m_c / CPB <= 8)
            m_dec[m_c / CPB - 1] = tx;
          m_c++;
          if (m_c == FRAME) begin
            check("byte", m_dec, m_cur);
            check("wave_err", m_wave_err, 0);
            check("tx_done_pos", m_done_err, 0);
            check("busy_in_frame", m_busy_err, 0);
            m_in_frame = 1'b0;
            m_post     = 1'b1;
            frames_seen++;
          end
        end
      end
    end
  end

  // Offer a byte and hold it until accepted; queue it as an expectation.
  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    data_in = b;
    data_valid = 1'b1;
    while (!ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      check("accept_timeout", t, 0);
      data_valid = 1'b0;
    end else begin
      @(posedge clk);
      accept_cyc = cyc;
      exp_q.push_back(b);
      #1;
      data_in = 8'($urandom);
      data_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", (t < 20000) ? 1 : 0, 1);
    repeat (3) @(negedge clk);
  endtask

  int a_cyc, f0, err, wv, dn, bs, hi;
  logic [7:0] rb;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_b_tx", b_tx, 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single byte 0x55
    start_q.delete();
    send(8'h55);
    wait_idle();
    check("start_latency", (start_q.size() > 0) ? start_q[0] - accept_cyc : -1, 1);

    // A5 then 3C into hold, F0 waits until the first frame drains
    start_q.delete();
    f0 = frames_seen;
    send(8'hA5);
    a_cyc = accept_cyc;
    send(8'h3C);
    check("hold_write_edge", accept_cyc - a_cyc, 1);
    @(negedge clk);
    check("ready_hold_full", ready, 0);
    send(8'hF0);
    check("f0_accept_edge", accept_cyc - a_cyc, FRAME + 1);
    wait_idle();
    check("three_frames", frames_seen - f0, 3);
    check("gap_1", (start_q.size() >= 2) ? start_q[1] - start_q[0] : -1, FRAME);
    check("gap_2", (start_q.size() >= 3) ? start_q[2] - start_q[1] : -1, FRAME);

    // 0x00 then 0xFF back to back
    start_q.delete();
    send(8'h00);
    send(8'hFF);
    wait_idle();
    check("gap_00_ff", (start_q.size() >= 2) ? start_q[1] - start_q[0] : -1, FRAME);

    // Reset 300 cycles into a 0xFF frame with hold full
    send(8'hFF);
    a_cyc = accept_cyc;
    send(8'h12);
    while (cyc < a_cyc + 300) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_tx", tx, 1);
    check("async_rst_ready", ready, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", tx_done, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    f0 = frames_seen;
    start_q.delete();
    err = 0;
    repeat (1500) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) err++;
    end
    check("quiet_after_rst", err, 0);
    check("no_frame_after_rst", start_q.size(), 0);
    send(8'h81);
    wait_idle();
    check("frame_0x81", frames_seen - f0, 1);

    // Randomized bytes with random gaps
    f0 = frames_seen;
    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom);
      if ($urandom_range(0, 3) == 0) repeat (1200) @(negedge clk);
      else repeat ($urandom_range(0, 3)) @(negedge clk);
      send(rb);
    end
    wait_idle();
    check("random_frames", frames_seen - f0, 10);

    // Two stop bits, byte 0x00
    @(negedge clk);
    b_data_in = 8'h00;
    b_valid = 1'b1;
    check("b_ready", b_ready, 1);
    @(posedge clk);
    #1 b_valid = 1'b0;
    b_data_in = 8'hFF;
    wv = 0; dn = 0; bs = 0; hi = 0;
    for (int c = 0; c < FRAME2; c++) begin
      @(negedge clk);
      if (b_tx !== ((c < 9 * CPB) ? 1'b0 : 1'b1)) wv++;
      if (b_tx_done !== (c == FRAME2 - 1)) dn++;
      if (b_busy !== 1'b1) bs++;
      if (b_tx === 1'b1) hi++;
    end
    check("b_wave", wv, 0);
    check("b_tx_done_pos", dn, 0);
    check("b_busy_in_frame", bs, 0);
    check("b_stop_high", hi, 2 * CPB);
    @(negedge clk);
    check("b_busy_fall", b_busy, 0);
    check("b_idle_tx", b_tx, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
